// File: rtl/regfile_arb_pkg.sv
// -----------------------------------------------------------------------------
// regfile_arb_pkg
// Shared types and default sizes for the register-file write-port arbiter.
//   arb_state_e : sequencer states (CLEAR runs the post-reset zero fill,
//                 RUN arbitrates the two writers)
//   req_id_t    : requester index (0 = writeback, 1 = auxiliary injector)
//   DEF_*       : default widths/depths used as parameter defaults
// -----------------------------------------------------------------------------
package regfile_arb_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_NREG   = 32;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } arb_state_e;

  typedef logic req_id_t;

  // The requester that gets priority after `id` has been served.
  function automatic req_id_t other_req(input req_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-input round-robin arbiter, purely combinational. The priority pointer
// register lives in the caller; this block computes the grant and the
// pointer value to load on the next edge.
// Ports:
//   en_i        : arbitration allowed this cycle (0 forces no grant)
//   valid_i     : request valids, bit N = requester N
//   prio_i      : requester favoured when both request
//   gnt_o       : one-hot grant (all zero when no grant)
//   gnt_any_o   : some requester granted
//   gnt_id_o    : index of the granted requester (meaningful with gnt_any_o)
//   prio_next_o : pointer for next cycle; moves off the winner, holds otherwise
// -----------------------------------------------------------------------------
module rr_arbiter2
  import regfile_arb_pkg::*;
(
  input  logic       en_i,
  input  logic [1:0] valid_i,
  input  req_id_t    prio_i,
  output logic [1:0] gnt_o,
  output logic       gnt_any_o,
  output req_id_t    gnt_id_o,
  output req_id_t    prio_next_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (valid_i == 2'b11) begin
        gnt_o = prio_i ? 2'b10 : 2'b01;
      end else begin
        gnt_o = valid_i;
      end
    end
  end

  assign gnt_any_o   = |gnt_o;
  assign gnt_id_o    = gnt_o[1];
  assign prio_next_o = gnt_any_o ? other_req(gnt_id_o) : prio_i;

endmodule

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
// Owns the single write port of the 32x32 register file. Writeback (req0) and
// the auxiliary injector (req1) share it round-robin; all rf_* outputs are
// registered so the file's negedge write sees values stable since the grant.
// Optional feature macro: REGARB_CLEAR_EN -- when defined, reset enters a
// CLEAR sequence that writes zero to every register (one per cycle) before
// arbitration starts. When undefined the block is permanently in RUN.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   reqN_valid/ready     : handshake per requester (ready is combinational)
//   reqN_addr/data       : write target and value
//   rf_rw/rf_addr/rf_data: registered register-file write port
//   busy                 : clear sequence in progress
//   gnt_cnt0/gnt_cnt1    : saturating accepted-request counters
// -----------------------------------------------------------------------------
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREG   = DEF_NREG,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              rf_rw,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              busy,
  output logic [CNT_W-1:0]  gnt_cnt0,
  output logic [CNT_W-1:0]  gnt_cnt1
);

  // The clear pointer wraps naturally only if the file exactly fills the
  // address space.
  if (NREG != (1 << ADDR_W)) begin : g_nreg_check
    $error("NREG must equal 2**ADDR_W");
  end

  logic              run_en;
  logic [1:0]        gnt;
  logic              gnt_any;
  req_id_t           gnt_id;
  req_id_t           prio_q;
  req_id_t           prio_d;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              rf_rw_q;
  logic [ADDR_W-1:0] rf_addr_q;
  logic [DATA_W-1:0] rf_data_q;
  logic [CNT_W-1:0]  cnt0_q;
  logic [CNT_W-1:0]  cnt1_q;

`ifdef REGARB_CLEAR_EN
  arb_state_e        state_q;
  logic [ADDR_W-1:0] ptr_q;

  assign run_en = (state_q == RUN);
  assign busy   = (state_q == CLEAR);
`else
  assign run_en = 1'b1;
  assign busy   = 1'b0;
`endif

  rr_arbiter2 u_arb (
    .en_i        (run_en),
    .valid_i     ({req1_valid, req0_valid}),
    .prio_i      (prio_q),
    .gnt_o       (gnt),
    .gnt_any_o   (gnt_any),
    .gnt_id_o    (gnt_id),
    .prio_next_o (prio_d)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign sel_addr   = gnt_id ? req1_addr : req0_addr;
  assign sel_data   = gnt_id ? req1_data : req0_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_rw_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
      prio_q    <= 1'b0;
`ifdef REGARB_CLEAR_EN
      state_q   <= CLEAR;
      ptr_q     <= '0;
`endif
    end else begin
`ifdef REGARB_CLEAR_EN
      if (state_q == CLEAR) begin
        // Register 0 is written here too, unlike in RUN.
        rf_rw_q   <= 1'b1;
        rf_addr_q <= ptr_q;
        rf_data_q <= '0;
        ptr_q     <= ptr_q + ADDR_W'(1);
        if (ptr_q == ADDR_W'(NREG - 1)) begin
          state_q <= RUN;
        end
      end else
`endif
      begin
        prio_q <= prio_d;
        if (gnt_any) begin
          // Address 0 is hardwired zero: accept the request but never write.
          rf_rw_q   <= (sel_addr != '0);
          rf_addr_q <= sel_addr;
          rf_data_q <= sel_data;
        end else begin
          rf_rw_q <= 1'b0;
        end
        if (gnt[0] && (cnt0_q != '1)) cnt0_q <= cnt0_q + CNT_W'(1);
        if (gnt[1] && (cnt1_q != '1)) cnt1_q <= cnt1_q + CNT_W'(1);
      end
    end
  end

  assign rf_rw    = rf_rw_q;
  assign rf_addr  = rf_addr_q;
  assign rf_data  = rf_data_q;
  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a cycle-level reference model.
// Counters are built 4 bits wide so saturation is reachable quickly.
module tb_regfile_write_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef REGARB_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic          rf_rw;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic          busy;
  logic [CW-1:0] gnt_cnt0, gnt_cnt1;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NREG(NR), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .rf_rw(rf_rw), .rf_addr(rf_addr), .rf_data(rf_data),
    .busy(busy), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stand-in register file driven by the DUT: writes on the falling edge.
  logic [31:0] tb_rf [NR];
  always @(negedge clk) if (rf_rw) tb_rf[rf_addr] <= rf_data;

  // ---------------- reference model ----------------
  int          m_clear_left;   // clear cycles still to issue
  int          m_last;         // requester served most recently
  bit          m_rw;
  int          m_addr;
  logic [31:0] m_data;
  int          m_cnt [2];
  logic [31:0] m_mem [NR];

  function automatic logic [1:0] exp_ready();
    if (m_clear_left > 0) return 2'b00;
    if (req0_valid && req1_valid) return (m_last == 0) ? 2'b10 : 2'b01;
    return {req1_valid, req0_valid};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_clear_left = CLEAR_EN ? NR : 0;
      m_last = 1;
      m_rw = 0; m_addr = 0; m_data = 0;
      m_cnt[0] = 0; m_cnt[1] = 0;
    end else if (m_clear_left > 0) begin
      m_rw = 1; m_addr = NR - m_clear_left; m_data = 0;
      m_clear_left--;
    end else begin
      logic [1:0] r;
      int g;
      r = exp_ready();
      if (r != 2'b00) begin
        g = r[1] ? 1 : 0;
        m_addr = (g == 1) ? int'(req1_addr) : int'(req0_addr);
        m_data = (g == 1) ? req1_data : req0_data;
        m_rw = (m_addr != 0);
        if (m_cnt[g] < CMAX) m_cnt[g]++;
        m_last = g;
        $display("txn req%0d addr=%0d data=0x%08h cnt=%0d", g, m_addr, m_data, m_cnt[g]);
      end else begin
        m_rw = 0;
      end
    end
  end

  always @(negedge clk) if (!rst && m_rw) m_mem[m_addr] = m_data;

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      logic [1:0] er;
      er = exp_ready();
      check("req0_ready", req0_ready, er[0]);
      check("req1_ready", req1_ready, er[1]);
      check("rf_rw", rf_rw, m_rw);
      check("rf_addr", rf_addr, m_addr);
      check("rf_data", rf_data, m_data);
      check("gnt_cnt0", gnt_cnt0, m_cnt[0]);
      check("gnt_cnt1", gnt_cnt1, m_cnt[1]);
      check("busy", busy, (m_clear_left > 0));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic drive(input bit v0, input int a0, input logic [31:0] d0,
                       input bit v1, input int a1, input logic [31:0] d1);
    req0_valid = v0; req0_addr = AW'(a0); req0_data = d0;
    req1_valid = v1; req1_addr = AW'(a1); req1_data = d1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_mem();
    for (int i = 0; i < NR; i++) check($sformatf("rf_reg%0d", i), tb_rf[i], m_mem[i]);
  endtask

  // Assert reset now (outputs must drop at once), release a cycle later and
  // optionally wait out the clear sequence, checking its length.
  task automatic do_reset(input bit wait_clear);
    int n;
    rst = 1'b1;
    #1;
    check("rst_rf_rw", rf_rw, 0);
    check("rst_rf_addr", rf_addr, 0);
    check("rst_rf_data", rf_data, 0);
    check("rst_cnt0", gnt_cnt0, 0);
    check("rst_cnt1", gnt_cnt1, 0);
    check("rst_busy", busy, CLEAR_EN);
    @(posedge clk); #2;
    rst = 1'b0;
    if (wait_clear) begin
      n = 0;
      while (busy === 1'b1 && n < 100) begin tick(); n++; end
      check("clear_len", n, CLEAR_EN ? NR : 0);
    end
  endtask

  localparam logic [1:0] MIX [12] = '{2'b01, 2'b11, 2'b11, 2'b10, 2'b00, 2'b11,
                                       2'b01, 2'b01, 2'b11, 2'b10, 2'b11, 2'b00};

  initial begin
    logic [1:0] mv;
    for (int i = 0; i < NR; i++) begin
      tb_rf[i] = 32'h5A5A_0000 + i;
      m_mem[i] = 32'h5A5A_0000 + i;
    end
    #2;
    do_reset(1'b1);
    check("reg12_after_reset", tb_rf[12], CLEAR_EN ? 32'h0 : 32'h5A5A_000C);
    check_mem();

`ifdef REGARB_CLEAR_EN
    // Reset during clear at ptr=10 restarts the sequence from 0.
    do_reset(1'b0);
    repeat (10) tick();
    check("midclear_addr", rf_addr, 9);
    do_reset(1'b1);
`endif

    // Single writeback request.
    drive(1, 12, 32'h0000_00A5, 0, 0, 0);
    #1;
    check("A_ready0", req0_ready, 1);
    check("A_ready1", req1_ready, 0);
    tick();
    idle();
    check("A_rf_rw", rf_rw, 1);
    check("A_rf_addr", rf_addr, 12);
    check("A_rf_data", rf_data, 32'hA5);
    #4;
    check("A_reg12", tb_rf[12], 32'hA5);
    tick();
    check("A_rw_drop", rf_rw, 0);

    // Both valid for four cycles from reset: 0,1,0,1.
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1, i + 1, 32'h100 + i, 1, i + 17, 32'h200 + i);
      #1;
      check($sformatf("B_ready0_%0d", i), req0_ready, (i % 2 == 0));
      check($sformatf("B_ready1_%0d", i), req1_ready, (i % 2 == 1));
      tick();
    end
    idle();
    check("B_cnt0", gnt_cnt0, 2);
    check("B_cnt1", gnt_cnt1, 2);

    // Auxiliary write to address 0: accepted, counted, never written.
    drive(0, 0, 0, 1, 0, 32'hFFFF_FFFF);
    #1;
    check("C_ready1", req1_ready, 1);
    tick();
    idle();
    check("C_rf_rw", rf_rw, 0);
    check("C_cnt1", gnt_cnt1, 3);
    #4;
    check("C_reg0", tb_rf[0], CLEAR_EN ? 32'h0 : 32'h5A5A_0000);

    // Mixed traffic checked by the model.
    for (int i = 0; i < 12; i++) begin
      mv = MIX[i];
      drive(mv[0], i, 32'hC000_0000 + i, mv[1], 31 - i, 32'hD000_0000 + i);
      tick();
    end
    idle();
    tick();
    check_mem();

    // Reset with traffic in flight drops the pending write.
    drive(1, 7, 32'h7777_7777, 1, 8, 32'h8888_8888);
    tick();
    do_reset(1'b1);
    idle();
    tick();
    check_mem();

    // Saturation: 17 grants into a 4-bit counter.
    for (int i = 0; i < 17; i++) begin
      drive(1, (i % 31) + 1, 32'hE000_0000 + i, 0, 0, 0);
      tick();
    end
    idle();
    check("D_cnt0_sat", gnt_cnt0, 15);
    check("D_cnt1", gnt_cnt1, 0);
    tick();
    check_mem();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
